// File: rtl/uart_rx_if.sv
// Serial-line side of the 8N1 UART receiver: incoming line plus received-byte outputs.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Frame_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop synchroniser, mid-bit sampling, stop-bit check,
// one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic     i_Clk,
  input  logic     i_Rst,
  uart_rx_if.slave rx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Half    = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StCleanup} state_e;

  state_e          state_q;
  logic            rx_meta_q;
  logic            r_Rx;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            dv_q;
  logic            err_q;
  logic            active_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      r_Rx      <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      rx_meta_q <= rx.i_Rx_Serial;
      r_Rx      <= rx_meta_q;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!r_Rx) begin
            state_q  <= StStart;
            active_q <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == Half) begin
            cnt_q <= '0;
            idx_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (!r_Rx) begin
              state_q <= StData;
            end else begin
              state_q  <= StIdle;
              active_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == LastCnt) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= r_Rx;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            state_q <= StCleanup;
            if (r_Rx) begin
              byte_q <= shift_q;
              dv_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCleanup: begin
          // Wait for the line to return high so a break is not seen as a new start bit.
          if (r_Rx) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_Rx_DV     = dv_q;
  assign rx.o_Rx_Byte   = byte_q;
  assign rx.o_Rx_Active = active_q;
  assign rx.o_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-level line driver, scoreboard of expected bytes,
// monitor collecting DV bytes and framing-error pulses.
module tb_uart_rx;
  localparam int unsigned Cpb = 87;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if rx_if ();

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .rx    (rx_if)
  );

  always #50 clk = ~clk;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_if.o_Rx_DV || rx_if.o_Frame_Err) begin
      tests++;
      if (rx_if.o_Rx_DV && rx_if.o_Frame_Err) begin
        fails++;
        $display("FAIL dv_err_exclusive: both high at cycle %0d, want at most one", cyc);
      end
      if (rx_if.o_Rx_DV) begin
        obs_q.push_back(rx_if.o_Rx_Byte);
        obs_cyc_q.push_back(cyc);
      end
      if (rx_if.o_Frame_Err) err_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Drives one frame starting at the current negedge; ends on a negedge with the line at stop.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end
    rx_if.i_Rx_Serial = 1'b0;
    start_cyc = cyc;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.i_Rx_Serial = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx_if.i_Rx_Serial = stop;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic test_reset();
    rx_if.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests += 4;
    if (rx_if.o_Rx_DV !== 1'b0) begin
      fails++; $display("FAIL reset_dv: got %b want 0", rx_if.o_Rx_DV);
    end
    if (rx_if.o_Frame_Err !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %b want 0", rx_if.o_Frame_Err);
    end
    if (rx_if.o_Rx_Active !== 1'b0) begin
      fails++; $display("FAIL reset_active: got %b want 0", rx_if.o_Rx_Active);
    end
    if (rx_if.o_Rx_Byte !== 8'h00) begin
      fails++; $display("FAIL reset_byte: got %h want 00", rx_if.o_Rx_Byte);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (rx_if.o_Rx_Active !== 1'b0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL idle_after_reset: active %b frames %0d want 0 0",
               rx_if.o_Rx_Active, obs_q.size());
    end
  endtask

  task automatic test_single();
    int e0;
    e0 = err_cnt;
    send_frame(8'h3F, 1'b1);
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      fails++;
      $display("FAIL single_count: got %0d frames want 1", obs_q.size());
    end else begin
      logic [7:0] got, want;
      int dt;
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      dt = obs_cyc_q.pop_front() - start_cyc;
      tests += 2;
      if (got !== want) begin
        fails++; $display("FAIL single_byte: got %h want %h", got, want);
      end
      if (dt < 824 || dt > 830) begin
        fails++; $display("FAIL single_latency: got %0d cycles want 827+-3", dt);
      end
    end
    tests++;
    if (err_cnt != e0) begin
      fails++; $display("FAIL single_no_err: got %0d errors want %0d", err_cnt, e0);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hAB, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d frames want 2", obs_q.size());
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    end else begin
      int c0, c1;
      c0 = obs_cyc_q.pop_front();
      c1 = obs_cyc_q.pop_front();
      for (int i = 0; i < 2; i++) begin
        logic [7:0] got, want;
        got = obs_q.pop_front();
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
          fails++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, want);
        end
      end
      tests++;
      if (c1 - c0 < 867 || c1 - c0 > 873) begin
        fails++; $display("FAIL b2b_spacing: got %0d cycles want about 870", c1 - c0);
      end
    end
  endtask

  task automatic test_glitch();
    int e0, n;
    e0 = err_cnt;
    rx_if.i_Rx_Serial = 1'b0;
    repeat (20) @(negedge clk);
    rx_if.i_Rx_Serial = 1'b1;
    n = 0;
    while (rx_if.o_Rx_Active !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rx_if.o_Rx_Active !== 1'b0) begin
      fails++; $display("FAIL glitch_active: got %b after 50 cycles want 0", rx_if.o_Rx_Active);
    end
    repeat (200) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || err_cnt != e0) begin
      fails++;
      $display("FAIL glitch_quiet: frames %0d errors %0d want 0 %0d", obs_q.size(), err_cnt, e0);
    end
    send_frame(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL glitch_next_count: got %0d frames want 1", obs_q.size());
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    end else begin
      logic [7:0] got, want;
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      void'(obs_cyc_q.pop_front());
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL glitch_next_byte: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_framing_error();
    int e0, n;
    logic [7:0] prev;
    e0 = err_cnt;
    prev = last_good;
    send_frame(8'hA5, 1'b0);
    repeat (250) @(negedge clk);
    tests++;
    if (rx_if.o_Rx_Active !== 1'b1) begin
      fails++; $display("FAIL ferr_active_hold: got %b want 1", rx_if.o_Rx_Active);
    end
    repeat (250) @(negedge clk);
    rx_if.i_Rx_Serial = 1'b1;
    n = 0;
    while (rx_if.o_Rx_Active !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rx_if.o_Rx_Active !== 1'b0) begin
      fails++; $display("FAIL ferr_release: active %b after 10 cycles want 0", rx_if.o_Rx_Active);
    end
    repeat (1000) @(negedge clk);
    tests += 3;
    if (err_cnt != e0 + 1) begin
      fails++; $display("FAIL ferr_pulse: got %0d errors want %0d", err_cnt, e0 + 1);
    end
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL ferr_no_dv: got %0d frames want 0", obs_q.size());
      obs_q.delete(); obs_cyc_q.delete();
    end
    if (rx_if.o_Rx_Byte !== prev) begin
      fails++; $display("FAIL ferr_byte_hold: got %h want %h", rx_if.o_Rx_Byte, prev);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    e0 = err_cnt;
    rx_if.i_Rx_Serial = 1'b0;
    repeat (Cpb) @(negedge clk);
    rx_if.i_Rx_Serial = 1'b1;
    repeat (4 * Cpb) @(negedge clk);
    rst = 1'b1;
    #1;
    tests += 4;
    if (rx_if.o_Rx_DV !== 1'b0) begin
      fails++; $display("FAIL midrst_dv: got %b want 0", rx_if.o_Rx_DV);
    end
    if (rx_if.o_Frame_Err !== 1'b0) begin
      fails++; $display("FAIL midrst_err: got %b want 0", rx_if.o_Frame_Err);
    end
    if (rx_if.o_Rx_Active !== 1'b0) begin
      fails++; $display("FAIL midrst_active: got %b want 0", rx_if.o_Rx_Active);
    end
    if (rx_if.o_Rx_Byte !== 8'h00) begin
      fails++; $display("FAIL midrst_byte: got %h want 00", rx_if.o_Rx_Byte);
    end
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10 * Cpb) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || err_cnt != e0) begin
      fails++;
      $display("FAIL midrst_quiet: frames %0d errors %0d want 0 %0d", obs_q.size(), err_cnt, e0);
      obs_q.delete(); obs_cyc_q.delete();
    end
    send_frame(8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL midrst_next_count: got %0d frames want 1", obs_q.size());
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    end else begin
      logic [7:0] got, want;
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      void'(obs_cyc_q.pop_front());
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL midrst_next_byte: got %h want %h", got, want);
      end
    end
  endtask

  // Bench-side transmitter stands in for uart_tx; its done point is the end of the stop bit.
  task automatic test_loopback();
    int done_cyc;
    send_frame(8'hAB, 1'b1);
    done_cyc = cyc;
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL loop_count: got %0d frames want 1", obs_q.size());
    end else begin
      logic [7:0] got, want;
      int c;
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      c = obs_cyc_q.pop_front();
      tests += 2;
      if (got !== want) begin
        fails++; $display("FAIL loop_byte: got %h want %h", got, want);
      end
      if (c > done_cyc + Cpb) begin
        fails++; $display("FAIL loop_timing: dv at %0d want <= %0d", c, done_cyc + Cpb);
      end
    end
  endtask

  initial begin
    rx_if.i_Rx_Serial = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, 8N1, LSB first; the receive-side counterpart of `uart_tx` in the image-processor serial link. It synchronises the asynchronous `i_Rx_Serial` line, detects and validates the start bit, samples each bit at mid-period, checks the stop bit and presents the byte with a one-cycle valid strobe. Bit timing is set by `CLKS_PER_BIT`, which must match the value used by `uart_tx` (87 for 115200 baud at a 10 MHz clock).

## Interface
- `CLKS_PER_BIT`, default 87: clocks per bit period; legal range ≥ 4.
- `i_Clk`  in  1  system clock; all logic on rising edge.
- `i_Rst`  in  1  asynchronous, active-high reset.
- `i_Rx_Serial`  in  1  asynchronous serial line; idle high.
- `o_Rx_DV`  out  1  one-cycle pulse; `o_Rx_Byte` is valid and updated on this cycle.
- `o_Rx_Byte`  out  8  last correctly framed byte; holds between frames.
- `o_Rx_Active`  out  1  high while a frame is in progress (all states except IDLE).
- `o_Frame_Err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- Synchroniser: 2 flops; `r_Rx` is the second flop; both reset to 1.
- `HALF = (CLKS_PER_BIT-1)/2` (integer); 87 → 43.
- Counter width is `$clog2(CLKS_PER_BIT)`. Bit index is 3 bits. Data shift register is 8 bits (internal).
- States:
  - IDLE: count=0, idx=0. If `r_Rx`==0 → START.
  - START: count increments each cycle until count==HALF. At HALF, if `r_Rx`==0 → DATA with count=0, idx=0. If not, the low pulse was a glitch → IDLE, with no outputs.
  - DATA: count runs to CLKS_PER_BIT-1; at that cycle `shift[idx] <= r_Rx` and count=0. If idx==7 → STOP; otherwise idx++.
  - STOP: count runs to CLKS_PER_BIT-1.
    - If `r_Rx`==1: `o_Rx_Byte <= shift`, `o_Rx_DV <= 1`.
    - If `r_Rx`==0: `o_Frame_Err <= 1`, and `o_Rx_Byte` is unchanged.
    - Either way → CLEANUP.
  - CLEANUP: stays until `r_Rx`==1, then → IDLE. This prevents a held-low line (break) from being taken as a new start bit.
- `o_Rx_DV` and `o_Frame_Err` are registered and cleared on every cycle they are not set. They are never high together.
- A new frame may begin the cycle after CLEANUP sees the line high. Back-to-back frames with a single stop bit must be received.

## Timing
- Reset values:
  - `o_Rx_DV`=0, `o_Frame_Err`=0, `o_Rx_Active`=0, `o_Rx_Byte`=8'h00.
  - state=IDLE; counters 0; shift register 0; synchroniser flops 1.
- Reset mid-frame aborts the frame immediately: no DV, no error, and the partial byte is discarded.
- If the line is low when reset deasserts, it is treated as a start bit. That frame normally ends in a framing error, then CLEANUP waits for the line to go high.
- Latency, with D = the edge at which IDLE sees `r_Rx`==0:
  - start bit sampled at D+HALF+1;
  - data bit n sampled at D+HALF+1+(n+1)·CLKS_PER_BIT;
  - stop bit sampled at D+HALF+1+9·CLKS_PER_BIT;
  - `o_Rx_DV` / `o_Frame_Err` high for exactly the cycle after the stop-bit sample.
- For 87 clocks/bit: the pulse follows D by 827 cycles. The pin edge precedes D by 2–3 cycles (synchroniser).
- `o_Rx_Active` rises the cycle after D. It falls on entry to IDLE, i.e. one cycle after CLEANUP sees the line high, or one cycle after a failed start check.
- Each bit is sampled once, near its centre. The allowed baud mismatch is about ±4 % over a 10-bit frame.

## Test plan
1. 10 MHz clock, 8700 ns bits, send 0x3F → exactly one `o_Rx_DV` pulse, `o_Rx_Byte`==8'h3F, `o_Frame_Err` stays 0, pulse 827±3 cycles after the start-bit falling edge.
2. Back-to-back 0xAB then 0x55, one stop bit, no gap → two DV pulses about 870 cycles apart, bytes 8'hAB then 8'h55.
3. Drive the line low for 20 clocks, then high → no DV, no error, `o_Rx_Active` returns to 0 within 50 cycles. A following 0x3C frame is received correctly.
4. Send 0xA5 with the stop bit driven 0, hold the line low 500 clocks, then release high → one `o_Frame_Err` pulse, no DV, `o_Rx_Byte` keeps its previous value. `o_Rx_Active` stays high until the line rises, and no spurious frame follows.
5. Assert `i_Rst` for 3 cycles after 4 data bits of 0xFF → all outputs go to reset values immediately, no pulse for the aborted frame. The next 0xC3 frame is received as 8'hC3.
6. Loopback: `uart_tx` serial output drives `i_Rx_Serial`, same `CLKS_PER_BIT`, transmit 0xAB → `o_Rx_DV` with 8'hAB, before or at `uart_tx` asserting its done flag plus 1 bit period.
